// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_res_e;

  // Number of asserted bits, saturated at 2 (all the frame logic needs).
  function automatic logic [1:0] low_count(input logic [ROWS-1:0] bits);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < ROWS; i++) n = n + {2'b00, bits[i]};
    return (n > 3'd2) ? 2'd2 : n[1:0];
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Column scan timebase: prescaler, column index, registered column drive,
// and a one-cycle sample enable in the last prescaler cycle of each slot.
module scan_tick
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic            CLK,
  input  logic            Reset,
  output logic [1:0]      col_idx,
  output logic [COLS-1:0] key_col,
  output logic            sample_en
);

  localparam int            CW   = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      col_q, col_d;
  logic [COLS-1:0] key_col_q, key_col_d;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    cnt_d     = cnt_q + CW'(1);
    col_d     = col_q;
    key_col_d = key_col_q;
    if (cnt_q == LAST) begin
      cnt_d     = '0;
      col_d     = col_q + 2'd1;
      key_col_d = ~(COLS'(1) << col_d);
    end
  end

  // NOTE: non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt_q     <= '0;
      col_q     <= 2'd0;
      key_col_q <= 4'b1110;
    end else begin
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      key_col_q <= key_col_d;
    end
  end

  assign col_idx   = col_q;
  assign key_col   = key_col_q;
  assign sample_en = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: per-frame classification of row samples and a
// debounce FSM that accepts a single key and strobes its code once.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [ROWS-1:0] KEY_ROW,
  output logic [COLS-1:0] KEY_COL,
  output logic [3:0]      KEY_CODE,
  output logic            KEY_VALID,
  output logic            KEY_STROBE
);

  localparam logic [3:0] DB_N = 4'(DEBOUNCE);

  logic [1:0] col_idx;
  logic       sample_en;
  logic       frame_end;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan_tick (
    .CLK       (CLK),
    .Reset     (Reset),
    .col_idx   (col_idx),
    .key_col   (KEY_COL),
    .sample_en (sample_en)
  );

  assign frame_end = sample_en && (col_idx == 2'd3);

  // Frame accumulation: saturated hit count plus the code of the first hit.
  logic [1:0]  acc_hits_q, acc_hits_d;
  logic [3:0]  acc_code_q, acc_code_d;
  logic [ROWS-1:0] row_low;
  logic [1:0]  samp_hits;
  logic [3:0]  samp_code;
  logic [2:0]  hit_sum;
  frame_res_e  frame_res;
  logic [3:0]  frame_code;

  assign row_low   = ~KEY_ROW;
  assign samp_hits = low_count(row_low);
  assign hit_sum   = {1'b0, acc_hits_q} + {1'b0, samp_hits};

  always_comb begin
    samp_code = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (row_low[r]) samp_code = {2'(r), col_idx};
    end

    // The column-3 sample is folded in combinationally at frame end.
    frame_code = (acc_hits_q == 2'd1) ? acc_code_q : samp_code;
    if (hit_sum == 3'd0)      frame_res = FR_NONE;
    else if (hit_sum == 3'd1) frame_res = FR_SINGLE;
    else                      frame_res = FR_MULTI;

    acc_hits_d = acc_hits_q;
    acc_code_d = acc_code_q;
    if (frame_end) begin
      acc_hits_d = 2'd0;
      acc_code_d = 4'd0;
    end else if (sample_en) begin
      acc_hits_d = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
      if (acc_hits_q == 2'd0) acc_code_d = samp_code;
    end
  end

  // Debounce FSM, stepped only at frame end.
  kp_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0] cand_q, cand_d;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;

  assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    code_d   = code_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_res == FR_SINGLE) begin
            cand_d = frame_code;
            if (DB_N == 4'd1) begin
              state_d  = ST_PRESSED;
              cnt_d    = 4'd0;
              code_d   = frame_code;
              valid_d  = 1'b1;
              strobe_d = 1'b1;
            end else begin
              state_d = ST_DEBOUNCE;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (frame_res == FR_SINGLE && frame_code == cand_q) begin
            if (cnt_inc >= DB_N) begin
              state_d  = ST_PRESSED;
              cnt_d    = 4'd0;
              code_d   = cand_q;
              valid_d  = 1'b1;
              strobe_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end
        ST_PRESSED: begin
          if (frame_res == FR_NONE) begin
            state_d = (DB_N == 4'd1) ? ST_IDLE : ST_RELEASE;
            cnt_d   = (DB_N == 4'd1) ? 4'd0 : 4'd1;
          end
        end
        ST_RELEASE: begin
          if (frame_res == FR_NONE) begin
            if (cnt_inc >= DB_N) begin
              state_d = ST_IDLE;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_PRESSED;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      acc_hits_q <= 2'd0;
      acc_code_q <= 4'd0;
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      cand_q     <= 4'd0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      acc_hits_q <= acc_hits_d;
      acc_code_q <= acc_code_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
    end
  end

  assign KEY_CODE   = code_q;
  assign KEY_VALID  = valid_q;
  assign KEY_STROBE = strobe_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=2 (16-cycle frames)
// and a behavioural 4x4 key matrix driving the row lines.
module tb_keypad_scan;

  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_strobe;
  logic [15:0] keys;

  int vec_cnt = 0;
  int err_cnt = 0;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .CLK        (clk),
    .Reset      (reset),
    .KEY_ROW    (key_row),
    .KEY_COL    (key_col),
    .KEY_CODE   (key_code),
    .KEY_VALID  (key_valid),
    .KEY_STROBE (key_strobe)
  );

  always #5 clk = ~clk;

  // Key k = 4*r + c shorts row r to column c.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          exp_strobes;
    logic [3:0]  exp_code;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold a key pattern for n frames, counting strobe-high cycles.
  task automatic run_frames(input logic [15:0] k, input int n,
                            output int strobes, output int last_at);
    keys    = k;
    strobes = 0;
    last_at = -1;
    for (int i = 1; i <= n * FRAME; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (key_strobe) begin
        strobes++;
        last_at = i;
      end
    end
  endtask

  initial begin
    int s, at;

    vecs[0]  = '{16'h0000, 9, 0, 4'h0, 1'b0};
    vecs[1]  = '{16'h0200, 3, 1, 4'h9, 1'b1};
    vecs[2]  = '{16'h0000, 2, 0, 4'h9, 1'b1};
    vecs[3]  = '{16'h0200, 1, 0, 4'h9, 1'b1};
    vecs[4]  = '{16'h0000, 1, 0, 4'h9, 1'b1};
    vecs[5]  = '{16'h0008, 2, 1, 4'h3, 1'b1};
    vecs[6]  = '{16'h0000, 2, 0, 4'h3, 1'b1};
    vecs[7]  = '{16'h0060, 4, 0, 4'h3, 1'b1};
    vecs[8]  = '{16'h0000, 1, 0, 4'h3, 1'b1};
    vecs[9]  = '{16'h0200, 2, 1, 4'h9, 1'b1};
    vecs[10] = '{16'h0000, 1, 0, 4'h9, 1'b1};
    vecs[11] = '{16'h0200, 1, 0, 4'h9, 1'b1};
    vecs[12] = '{16'h0000, 2, 0, 4'h9, 1'b1};
    vecs[13] = '{16'h0200, 2, 1, 4'h9, 1'b1};
    vecs[14] = '{16'h0000, 2, 0, 4'h9, 1'b1};
    vecs[15] = '{16'h0011, 3, 0, 4'h9, 1'b1};
    vecs[16] = '{16'h8000, 2, 1, 4'hF, 1'b1};
    vecs[17] = '{16'h0000, 2, 0, 4'hF, 1'b1};
    vecs[18] = '{16'h0001, 2, 1, 4'h0, 1'b1};
    vecs[19] = '{16'h0000, 2, 0, 4'h0, 1'b1};
    vecs[20] = '{16'h0080, 1, 0, 4'h0, 1'b1};
    vecs[21] = '{16'h0100, 2, 0, 4'h0, 1'b1};
    vecs[22] = '{16'h0100, 1, 1, 4'h8, 1'b1};
    vecs[23] = '{16'h0000, 2, 0, 4'h8, 1'b1};

    reset = 1'b1;
    keys  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_col",    32'(key_col),    32'hE);
    check("rst_code",   32'(key_code),   32'h0);
    check("rst_valid",  32'(key_valid),  32'h0);
    check("rst_strobe", 32'(key_strobe), 32'h0);

    // First idle frame: column drive walks every 4 cycles.
    reset = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      logic [3:0] exp_col;
      @(posedge clk);
      @(negedge clk);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check($sformatf("col_walk_%0d", k), 32'(key_col), 32'(exp_col));
      check($sformatf("idle_strobe_%0d", k), 32'(key_strobe), 32'h0);
    end

    for (int i = 0; i < 24; i++) begin
      run_frames(vecs[i].keys, vecs[i].frames, s, at);
      check($sformatf("v%0d_strobes", i), 32'(s), 32'(vecs[i].exp_strobes));
      check($sformatf("v%0d_code", i),    32'(key_code),  32'(vecs[i].exp_code));
      check($sformatf("v%0d_valid", i),   32'(key_valid), 32'(vecs[i].exp_valid));
    end

    // Exact accept latency: strobe in the cycle after the second frame end.
    run_frames(16'h0400, 2, s, at);
    check("lat_strobes", 32'(s), 32'd1);
    check("lat_cycle",   32'(at), 32'(2 * FRAME));
    check("lat_code",    32'(key_code), 32'hA);
    run_frames(16'h0000, 2, s, at);

    // Reset after one debounce frame of key 12 discards the candidate.
    run_frames(16'h1000, 1, s, at);
    check("mid_strobes", 32'(s), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_col",    32'(key_col),    32'hE);
    check("mid_rst_code",   32'(key_code),   32'h0);
    check("mid_rst_valid",  32'(key_valid),  32'h0);
    check("mid_rst_strobe", 32'(key_strobe), 32'h0);
    run_frames(16'h1000, 1, s, at);
    check("post_rst_f1_strobes", 32'(s), 32'd0);
    check("post_rst_f1_valid",   32'(key_valid), 32'h0);
    run_frames(16'h1000, 1, s, at);
    check("post_rst_f2_strobes", 32'(s), 32'd1);
    check("post_rst_f2_at",      32'(at), 32'(FRAME));
    check("post_rst_code",       32'(key_code), 32'hC);
    check("post_rst_valid",      32'(key_valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles each column is driven; legal range 2..65535.
REQ-002 Parameter DEBOUNCE, default 4, consecutive identical scan frames required to accept a press or a release; legal range 1..15.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 KEY_ROW  input  4  keypad row lines, active-low (pulled up externally), bit r = row r.
REQ-006 KEY_COL  output  4  keypad column drive, active-low, exactly one bit low at any time.
REQ-007 KEY_CODE  output  4  code of last accepted key, feeds the downstream BCD/seven-segment display input I3..I0.
REQ-008 KEY_VALID  output  1  high once any key has been accepted since reset.
REQ-009 KEY_STROBE  output  1  one-cycle pulse when a new key is accepted.

Function
REQ-010 A prescaler shall count 0..SCAN_DIV-1 and wrap; the column index shall advance 0->1->2->3->0 on each wrap.
REQ-011 KEY_COL shall be ~(4'b0001 << column index), registered.
REQ-012 KEY_ROW shall be sampled only in the last prescaler cycle (count = SCAN_DIV-1) of each column slot, giving rows time to settle.
REQ-013 A frame is the four column slots 0..3; frame result evaluated at the last sample of column 3: NONE (no low row bit), SINGLE(k) (exactly one low bit in whole frame), MULTI (two or more).
REQ-014 Key code for row r, column c shall be k = 4*r + c (0..15).
REQ-015 FSM states IDLE, DEBOUNCE, PRESSED, RELEASE; transitions evaluated only at frame end.
REQ-016 IDLE: SINGLE(k) -> DEBOUNCE with candidate=k, count=1 (if DEBOUNCE=1, accept immediately and go to PRESSED); NONE/MULTI -> stay.
REQ-017 DEBOUNCE: SINGLE(candidate) -> count+1, and when count reaches DEBOUNCE accept and go to PRESSED; SINGLE(other)/NONE/MULTI -> IDLE, count cleared.
REQ-018 Accept: KEY_CODE <= candidate, KEY_VALID <= 1, KEY_STROBE high for exactly the next clock cycle after the frame-end edge.
REQ-019 PRESSED: NONE -> RELEASE with count=1 (DEBOUNCE=1 -> IDLE directly); SINGLE/MULTI -> stay; no auto-repeat strobes while held.
REQ-020 RELEASE: NONE -> count+1, IDLE when count reaches DEBOUNCE; SINGLE/MULTI -> PRESSED, count cleared.
REQ-021 KEY_CODE and KEY_VALID shall hold their values across release; only a new accept changes KEY_CODE.
REQ-022 Debounce counter 4 bits, never wraps; prescaler width = ceil(log2(SCAN_DIV)).
REQ-023 Accept-to-strobe latency: 1 cycle after the frame-end sampling edge; press-to-strobe minimum DEBOUNCE frames.

Reset
REQ-024 While Reset is high at a rising edge: prescaler=0, column=0, KEY_COL=4'b1110, state IDLE, count=0, frame accumulators cleared, KEY_CODE=4'h0, KEY_VALID=0, KEY_STROBE=0.
REQ-025 Reset asserted mid-debounce or mid-frame shall discard the partial frame and candidate; no strobe shall be produced in the cycle after reset.

Structure
REQ-026 Shared package keypad_pkg shall hold the FSM state encoding (2 bits), ROWS=4, COLS=4, and the frame-result encoding (NONE/SINGLE/MULTI).
REQ-027 One sub-module scan_tick shall contain the prescaler and column counter, outputting column index and a sample-enable pulse; frame evaluation and FSM stay in keypad_scan.

Verification (bench uses SCAN_DIV=4, DEBOUNCE=2; frame = 16 cycles)
REQ-028 Reset released, no key -> KEY_COL cycles 1110,1101,1011,0111 every 4 cycles; KEY_VALID=0, no strobe for 10 frames.
REQ-029 Hold row 2 low while column 1 driven, for 3 frames -> one KEY_STROBE at end of frame 2 +1 cycle, KEY_CODE=4'h9, KEY_VALID=1; no further strobe while held.
REQ-030 Key 9 pressed 1 frame then released, then key 3 (row 0, col 3) held 2 frames -> no strobe for 9; strobe with KEY_CODE=4'h3.
REQ-031 Keys 5 and 6 held together 4 frames -> no strobe, KEY_CODE unchanged.
REQ-032 Key 9 accepted, released for 1 frame, pressed again -> no second strobe (RELEASE->PRESSED); released 2 frames then pressed 2 frames -> second strobe, KEY_CODE=4'h9.
REQ-033 Reset pulsed after 1 debounce frame of key 12 -> outputs at reset values, KEY_COL=1110; key still held -> strobe only after 2 further full frames, KEY_CODE=4'hC.
